// File: rtl/fetch_stage_pkg.sv
// Shared opcode and fetch definitions for the MIPS pipeline front end.
package fetch_stage_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [OPCODE_W-1:0] {
      OP_RTYPE = 6'b000000,
      OP_BEQ   = 6'b000100,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_e;

   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: async reset, load enable, redirect mux with word alignment, +4 increment.
module fetch_stage_pc_register
   import fetch_stage_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4_c
);

   logic [ADDR_W-1:0] next_pc;

   // Increment wraps silently at the top of the address space.
   always_comb begin
      pc_plus4_c = pc + ADDR_W'(4);
      next_pc    = pc_plus4_c;
      if (redirect) begin
         next_pc = target & ~ADDR_W'(3);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= next_pc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, branch redirect, stall and flush.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               PCSrc,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               stall,
   input  logic               flush,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc4,
   output logic               if_id_valid
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              pc_load;
   logic              squash;

   // Redirect and flush both override a stall; only a bare stall freezes the PC.
   always_comb begin
      squash  = PCSrc | flush;
      pc_load = squash | ~stall;
   end

   fetch_stage_pc_register #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst        (rst),
      .load       (pc_load),
      .redirect   (PCSrc),
      .target     (branch_target),
      .pc         (pc),
      .pc_plus4_c (pc_plus4)
   );

   assign imem_addr = pc;

   // IF/ID register: bubble on squash, hold on stall, otherwise capture the fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (squash) begin
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         if_id_instr <= imem_data;
         if_id_pc4   <= pc_plus4;
         if_id_valid <= 1'b1;
      end
   end

endmodule
